// File: rtl/relu_pkg.sv
// Shared types and the ReLU select function for the relu_binary_clk datapath.
// RELU_CLIP_EN selects the bounded ReLU variant of relu_f.
package relu_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef logic signed [DEFAULT_DATA_W-1:0] data_t;

`ifdef RELU_CLIP_EN
  // Bounded ReLU: the sign bit forces zero; non-negative values saturate at clip.
  function automatic data_t relu_f(input data_t x, input data_t clip);
    data_t y;
    if (x[DEFAULT_DATA_W-1]) begin
      y = '0;
    end else if (x > clip) begin
      y = clip;
    end else begin
      y = x;
    end
    return y;
  endfunction
`else
  function automatic data_t relu_f(input data_t x);
    return x[DEFAULT_DATA_W-1] ? data_t'(0) : x;
  endfunction
`endif

endpackage

// File: rtl/relu_core.sv
// Combinational ReLU: sign-bit select, plus an upper clamp when RELU_CLIP_EN is defined.
module relu_core
  import relu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
`ifdef RELU_CLIP_EN
  ,
  parameter int CLIP_VAL = 127
`endif
) (
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data
);

`ifdef RELU_CLIP_EN
  localparam logic [DATA_W-1:0] CLIP_W = DATA_W'(CLIP_VAL);
`endif

  generate
    if (DATA_W == DEFAULT_DATA_W) begin : g_pkg
`ifdef RELU_CLIP_EN
      always_comb out_data = relu_f(data_t'(in_data), data_t'(CLIP_W));
`else
      always_comb out_data = relu_f(data_t'(in_data));
`endif
    end else begin : g_generic
      // Non-default widths cannot use the fixed-width package type.
      always_comb begin
        out_data = in_data[DATA_W-1] ? '0 : in_data;
`ifdef RELU_CLIP_EN
        if (!in_data[DATA_W-1] && (in_data > CLIP_W)) begin
          out_data = CLIP_W;
        end
`endif
      end
    end
  endgenerate

endmodule

// File: rtl/relu_binary_clk.sv
// Registered ReLU with a LATENCY-deep register chain and asynchronous active-high reset.
// Defining RELU_CLIP_EN turns on the CLIP_VAL upper clamp; latency is unchanged.
module relu_binary_clk
  import relu_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int LATENCY  = 1,
  parameter int CLIP_VAL = 127
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data
);

  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("relu_binary_clk: LATENCY must be in 1..4");
    end
    if (CLIP_VAL < 1 || CLIP_VAL > (2 ** (DATA_W - 1)) - 1) begin : g_bad_clip
      $error("relu_binary_clk: CLIP_VAL must be in 1..2^(DATA_W-1)-1");
    end
  endgenerate

  logic [DATA_W-1:0] relu_y;

  relu_core #(
    .DATA_W  (DATA_W)
`ifdef RELU_CLIP_EN
    ,
    .CLIP_VAL(CLIP_VAL)
`endif
  ) u_core (
    .in_data (in_data),
    .out_data(relu_y)
  );

  // Stage 0 captures the ReLU result directly, so LATENCY=1 is a single register.
  genvar g;
  generate
    for (g = 0; g < LATENCY; g++) begin : g_stage
      logic [DATA_W-1:0] stage_d;
      logic [DATA_W-1:0] stage_q;

      if (g == 0) begin : g_first
        always_comb stage_d = relu_y;
      end else begin : g_next
        always_comb stage_d = g_stage[g-1].stage_q;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stage_q <= '0;
        end else begin
          stage_q <= stage_d;
        end
      end
    end
  endgenerate

  assign out_data = g_stage[LATENCY-1].stage_q;

endmodule

// File: tb/tb_relu_binary_clk.sv
// Bench for relu_binary_clk: LATENCY=1 and LATENCY=3 instances fed the same stream,
// scored against a reference model through expected-value queues.
module tb_relu_binary_clk;

`ifdef RELU_CLIP_EN
  localparam int CLIP = 6;
`else
  localparam int CLIP = 127;
`endif
  localparam int LAT3 = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h55;
  logic [7:0] out1;
  logic [7:0] out3;

  always #5 clk = ~clk;

  relu_binary_clk #(.DATA_W(8), .LATENCY(1), .CLIP_VAL(CLIP)) u_dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .out_data(out1)
  );

  relu_binary_clk #(.DATA_W(8), .LATENCY(LAT3), .CLIP_VAL(CLIP)) u_dut3 (
    .clk(clk), .reset(reset), .in_data(in_data), .out_data(out3)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp1_q[$];
  logic [7:0] exp3_q[$];
  int         total = 0;
  int         bad = 0;
  bit         mon_en = 1'b0;

  // Reference model: ReLU computed on the integer value of the signed sample.
  function automatic logic [7:0] ref_relu(input logic [7:0] x);
    int v;
    v = $signed(x);
    if (v < 0) v = 0;
`ifdef RELU_CLIP_EN
    if (v > CLIP) v = CLIP;
`endif
    return v[7:0];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%02h) want %0d (0x%02h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (reset) begin
      check("out1_in_reset", out1, 8'h00);
      check("out3_in_reset", out3, 8'h00);
    end else if (mon_en) begin
      if (exp1_q.size() == 0 || exp3_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got empty queue want pending expectation at %0t", $time);
      end else begin
        check("out1_lat1", out1, exp1_q.pop_front());
        check("out3_lat3", out3, exp3_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (called on a falling edge) ----------------
  task automatic drive(input logic [7:0] x);
    in_data = x;
    exp1_q.push_back(ref_relu(x));
    exp3_q.push_back(ref_relu(x));
    @(negedge clk);
  endtask

  task automatic pipe_empty();
    exp1_q.delete();
    exp3_q.delete();
    for (int i = 0; i < LAT3 - 1; i++) exp3_q.push_back(8'h00);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    #1;
    check("out1_async_reset", out1, 8'h00);
    check("out3_async_reset", out3, 8'h00);
    in_data = 8'h55;
    exp1_q.delete();
    exp3_q.delete();
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    pipe_empty();
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] dir_vec[] = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h2A, 8'h7F};
  logic [7:0] clip_vec[] = '{8'hFB, 8'h03, 8'h06, 8'h2A};

  initial begin
    #1;
    check("out1_reset_t0", out1, 8'h00);
    check("out3_reset_t0", out3, 8'h00);
    @(negedge clk);
    // Reset held with 0x55 on the input for three edges.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    pipe_empty();
    mon_en = 1'b1;

    foreach (dir_vec[i]) drive(dir_vec[i]);

    // Asserted between edges while out1 shows 127: outputs must drop at once.
    do_reset(2);

    // Reset mid-stream.
    drive(8'h7F);
    drive(8'h7F);
    do_reset(1);
    drive(8'h02);

    // Impulse through the LATENCY=3 pipeline.
    drive(8'h00);
    drive(8'h00);
    drive(8'h10);
    repeat (4) drive(8'h00);

    foreach (clip_vec[i]) drive(clip_vec[i]);

    for (int c = 0; c < 256; c++) drive(8'(c));

    repeat (200) drive(8'($urandom_range(0, 255)));

    drive(8'h00);
    do_reset(1);
    repeat (LAT3) drive(8'h00);
    mon_en = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
